// File: rtl/arbiter_rr_pkt.sv
// N-way valid/ready arbiter (round-robin or fixed priority) with optional packet
// locking and a single registered output stage.
module arbiter_rr_pkt #(
    parameter int BUS_NUM  = 32,
    parameter int DW       = 8,
    parameter int MODE     = 0,
    parameter int PKT_LOCK = 1,
    localparam int IW      = $clog2(BUS_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_NUM-1:0]    valid_in,
    input  logic [BUS_NUM*DW-1:0] data_in,
    input  logic [BUS_NUM-1:0]    last_in,
    output logic [BUS_NUM-1:0]    ready_out,
    output logic                  valid_out,
    output logic [DW-1:0]         data_out,
    output logic                  last_out,
    output logic [IW-1:0]         src_out,
    input  logic                  ready_in
);

    // Handshake: a beat moves on any edge where valid and ready are both high.
    // Upstream valid_in must not depend on ready_out; ready_out may depend on
    // ready_in. valid_out/data_out/last_out/src_out hold while valid_out & !ready_in.

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e state_q, state_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          valid_out_q, valid_out_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          last_out_q, last_out_d;
    logic [IW-1:0] src_out_q, src_out_d;

    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [DW-1:0] grant_data;
    logic          grant_last;
    logic          load;
    logic          xfer;
    logic          pkt_final;

    // Grant selection; loops run backwards so the first match in scan order wins.
    always_comb begin
        logic [IW:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (state_q == ST_LOCKED) begin
            if (valid_in[lock_idx_q]) begin
                grant_valid = 1'b1;
                grant_idx   = lock_idx_q;
            end
        end else if (MODE == 1) begin
            for (int k = BUS_NUM - 1; k >= 0; k--) begin
                if (valid_in[IW'(k)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IW'(k);
                end
            end
        end else begin
            for (int i = BUS_NUM - 1; i >= 0; i--) begin
                cand = {1'b0, ptr_q} + (IW+1)'(i);
                if (cand >= (IW+1)'(BUS_NUM)) begin
                    cand = cand - (IW+1)'(BUS_NUM);
                end
                if (valid_in[cand[IW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int k = 0; k < BUS_NUM; k++) begin
            if (grant_idx == IW'(k)) begin
                grant_data = data_in[k*DW +: DW];
                grant_last = last_in[k];
            end
        end
    end

    always_comb begin
        load      = !valid_out_q || ready_in;
        xfer      = load && grant_valid;
        pkt_final = (PKT_LOCK == 0) || grant_last;

        ready_out = '0;
        if (xfer && !rst) begin
            ready_out[grant_idx] = 1'b1;
        end

        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        last_out_d  = last_out_q;
        src_out_d   = src_out_q;
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        ptr_d       = ptr_q;

        if (load) begin
            valid_out_d = xfer;
        end
        if (xfer) begin
            data_out_d = grant_data;
            last_out_d = grant_last;
            src_out_d  = grant_idx;
            if (PKT_LOCK != 0) begin
                if (grant_last) begin
                    state_d = ST_OPEN;
                end else begin
                    state_d    = ST_LOCKED;
                    lock_idx_d = grant_idx;
                end
            end
            // Explicit wrap keeps the pointer legal for non-power-of-2 BUS_NUM.
            if ((MODE == 0) && pkt_final) begin
                ptr_d = (grant_idx == IW'(BUS_NUM - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OPEN;
            lock_idx_q  <= '0;
            ptr_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            last_out_q  <= 1'b0;
            src_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            ptr_q       <= ptr_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            last_out_q  <= last_out_d;
            src_out_q   <= src_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign last_out  = last_out_q;
    assign src_out   = src_out_q;

endmodule

// File: tb/tb_arbiter_rr_pkt.sv
// Bench for arbiter_rr_pkt: a round-robin instance and a fixed-priority instance,
// each checked against a packet-level reference model through an expected-beat queue.
module tb_arbiter_rr_pkt;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int EW = 3 + 1 + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    valid_in  [2];
    logic [N*DW-1:0] data_in   [2];
    logic [N-1:0]    last_in   [2];
    logic [N-1:0]    ready_out [2];
    logic            valid_out [2];
    logic [DW-1:0]   data_out  [2];
    logic            last_out  [2];
    logic [2:0]      src_out   [2];
    logic            ready_in  [2];

    arbiter_rr_pkt #(.BUS_NUM(N), .DW(DW), .MODE(0), .PKT_LOCK(1)) u_rr (
        .clk(clk), .rst(rst),
        .valid_in(valid_in[0]), .data_in(data_in[0]), .last_in(last_in[0]),
        .ready_out(ready_out[0]), .valid_out(valid_out[0]), .data_out(data_out[0]),
        .last_out(last_out[0]), .src_out(src_out[0]), .ready_in(ready_in[0])
    );

    arbiter_rr_pkt #(.BUS_NUM(N), .DW(DW), .MODE(1), .PKT_LOCK(1)) u_fp (
        .clk(clk), .rst(rst),
        .valid_in(valid_in[1]), .data_in(data_in[1]), .last_in(last_in[1]),
        .ready_out(ready_out[1]), .valid_out(valid_out[1]), .data_out(data_out[1]),
        .last_out(last_out[1]), .src_out(src_out[1]), .ready_in(ready_in[1])
    );

    // Expected output beats {src, last, data}, one queue per instance.
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    // Upstream sources: per instance, per channel FIFO of {last, data}.
    logic [DW:0] sbuf [2][N][256];
    int shead [2][N];
    int stail [2][N];

    // Reference model state.
    int m_ptr    [2];
    bit m_locked [2];
    int m_lidx   [2];
    bit m_vout   [2];
    int mode_of  [2];

    bit rst_req = 1'b1;
    bit gap_rand = 1'b0;
    int rdy_mode [2];
    bit force_gap [2][N];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int m, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, m, $time, act, exp);
        end
    endtask

    function automatic int q_size(input int m);
        return (m == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [EW-1:0] q_head(input int m);
        return (m == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic q_push(input int m, input logic [EW-1:0] v);
        if (m == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic q_pop(input int m);
        if (m == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endtask

    task automatic q_clear(input int m);
        if (m == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    function automatic bit src_empty(input int m, input int k);
        return shead[m][k] == stail[m][k];
    endfunction

    task automatic enq_beat(input int m, input int k, input logic [DW-1:0] d, input logic lst);
        sbuf[m][k][stail[m][k] & 255] = {lst, d};
        stail[m][k]++;
    endtask

    task automatic enq(input int m, input int k, input int len);
        for (int b = 0; b < len; b++) begin
            enq_beat(m, k, 8'($urandom_range(0, 255)), (b == len - 1));
        end
    endtask

    // Which channel the rules say wins this cycle, -1 for none.
    function automatic int model_grant(input int m, input logic [N-1:0] v);
        int k;
        if (m_locked[m]) return v[m_lidx[m]] ? m_lidx[m] : -1;
        for (int i = 0; i < N; i++) begin
            k = (mode_of[m] == 1) ? i : (m_ptr[m] + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // One clock: drive at negedge, predict and check handshake 1ns later.
    task automatic step();
        logic [DW:0]  hd;
        logic [N-1:0] exp_r;
        logic [2:0]   gs;
        int g;
        bit load;
        @(negedge clk);
        rst = rst_req;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < N; k++) begin
                hd = sbuf[m][k][shead[m][k] & 255];
                valid_in[m][k] = !src_empty(m, k) && !force_gap[m][k]
                                 && !(gap_rand && ($urandom_range(0, 3) == 0));
                data_in[m][k*DW +: DW] = hd[DW-1:0];
                last_in[m][k] = hd[DW];
                force_gap[m][k] = 1'b0;
            end
            ready_in[m] = (rdy_mode[m] == 0) ? 1'b1 :
                          (rdy_mode[m] == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                chk("rst_ready_out", m, ready_out[m], 0);
                chk("rst_valid_out", m, valid_out[m], 0);
                chk("rst_data_out", m, data_out[m], 0);
                chk("rst_last_out", m, last_out[m], 0);
                chk("rst_src_out", m, src_out[m], 0);
                m_ptr[m] = 0;
                m_locked[m] = 1'b0;
                m_lidx[m] = 0;
                m_vout[m] = 1'b0;
                q_clear(m);
            end else begin
                chk("valid_out", m, valid_out[m], m_vout[m]);
                load = !m_vout[m] || ready_in[m];
                g = model_grant(m, valid_in[m]);
                exp_r = '0;
                if (load && g >= 0) exp_r[g] = 1'b1;
                chk("ready_out", m, ready_out[m], exp_r);
                if (load) m_vout[m] = (g >= 0);
                if (load && g >= 0) begin
                    hd = sbuf[m][g][shead[m][g] & 255];
                    shead[m][g]++;
                    gs = 3'(g);
                    q_push(m, {gs, hd});
                    m_locked[m] = !hd[DW];
                    if (!hd[DW]) m_lidx[m] = g;
                    if (hd[DW] && mode_of[m] == 0) m_ptr[m] = (g + 1) % N;
                end
            end
        end
    endtask

    // Monitor: every presented output beat must equal the oldest expected beat.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int m = 0; m < 2; m++) begin
                if (!rst && valid_out[m]) begin
                    if (q_size(m) == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_beat dut%0d t=%0t: got src %0d data %0h, expected no beat",
                                 m, $time, src_out[m], data_out[m]);
                    end else begin
                        chk("out_beat", m, {src_out[m], last_out[m], data_out[m]}, q_head(m));
                        if (ready_in[m]) q_pop(m);
                    end
                end
            end
        end
    end

    function automatic bit all_idle();
        for (int m = 0; m < 2; m++) begin
            if (q_size(m) != 0) return 1'b0;
            for (int k = 0; k < N; k++) if (!src_empty(m, k)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain();
        int cnt;
        cnt = 0;
        gap_rand = 1'b0;
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        do begin
            step();
            cnt++;
        end while (!all_idle() && cnt < 400);
        if (!all_idle()) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout t=%0t: got traffic pending after %0d cycles, expected idle", $time, cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t: got no finish, expected end of run", $time);
        $fatal(1);
    end

    initial begin
        mode_of[0] = 0;
        mode_of[1] = 1;
        for (int m = 0; m < 2; m++) begin
            valid_in[m] = '0;
            data_in[m] = '0;
            last_in[m] = '0;
            ready_in[m] = 1'b1;
            rdy_mode[m] = 0;
            m_ptr[m] = 0;
            m_locked[m] = 1'b0;
            m_lidx[m] = 0;
            m_vout[m] = 1'b0;
            for (int k = 0; k < N; k++) begin
                shead[m][k] = 0;
                stail[m][k] = 0;
                force_gap[m][k] = 1'b0;
            end
        end

        // Reset with every channel valid, then grants 0,1,2,3,4,0,...
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < N; k++) begin
                enq(m, k, 1);
                enq(m, k, 1);
            end
        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;
        drain();

        // Round-robin wrap between channels 4 and 0.
        for (int i = 0; i < 4; i++) begin
            enq(0, 4, 1);
            enq(0, 0, 1);
        end
        drain();

        // Backpressure: 0xA5 held for 4 stalled cycles while others wait.
        enq_beat(0, 0, 8'hA5, 1'b1);
        step();
        enq(0, 1, 2);
        enq(0, 2, 1);
        rdy_mode[0] = 2;
        repeat (4) step();
        drain();

        // Packet lock: ch2 three beats with a one-cycle valid drop, ch1 waiting.
        enq(0, 1, 1);
        drain();
        enq(0, 2, 3);
        for (int i = 0; i < 3; i++) enq(0, 1, 1);
        step();
        force_gap[0][2] = 1'b1;
        step();
        drain();

        // Reset mid-packet: ch3 locked 4-beat packet, ch0 valid throughout.
        enq(0, 3, 4);
        enq(0, 0, 2);
        step();
        step();
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0;
        drain();

        // Fixed priority: valid pattern 5'b10110.
        for (int i = 0; i < 3; i++) enq(1, 1, 1);
        enq(1, 2, 1);
        enq(1, 2, 1);
        enq(1, 4, 1);
        enq(1, 4, 1);
        drain();

        // Random packets, gaps and backpressure on both instances.
        gap_rand = 1'b1;
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        repeat (1500) begin
            for (int m = 0; m < 2; m++)
                for (int k = 0; k < N; k++)
                    if (src_empty(m, k) && $urandom_range(0, 3) == 0)
                        enq(m, k, $urandom_range(1, 4));
            step();
        end
        drain();

        chk("leftover_dut0", 0, exp_q0.size(), 0);
        chk("leftover_dut1", 1, exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_pkt.md
Name: arbiter_rr_pkt

Overview:
- Single-level N-way valid/ready arbiter with a registered output stage.
- Any BUS_NUM ≥ 2 is supported, including non-powers-of-4 and non-powers-of-2.
- Arbitration mode is selectable: round-robin or fixed priority.
- Optional packet locking keeps a grant held until the granted source's last beat.
- Used as a flat replacement for tree arbitration, or as a tree node where fairness and packet atomicity matter.

Parameters:
- BUS_NUM, 32, number of upstream channels (≥ 2).
- DW, 8, data width per channel.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (index 0 highest).
- PKT_LOCK, 1, packet locking: 1 = grant held from first beat through last beat; 0 = re-arbitrate every beat.
- IW, $clog2(BUS_NUM), source index width (derived localparam; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  BUS_NUM  per-channel valid.
- data_in  input  BUS_NUM*DW  channel k occupies bits [DW*(k+1)-1 : DW*k].
- last_in  input  BUS_NUM  per-channel end-of-packet flag.
- ready_out  output  BUS_NUM  per-channel ready; at most one bit high.
- valid_out  output  1  output beat valid.
- data_out  output  DW  output beat data.
- last_out  output  1  output beat last flag.
- src_out  output  IW  index of the channel that produced the current output beat.
- ready_in  input  1  downstream ready.

Behaviour:
- Reset (async assert): valid_out=0, data_out=0, last_out=0, src_out=0, rr pointer=0, locked=0, lock_idx=0.
  - ready_out is forced to all-zero while rst=1.
- Output register load enable: load = !valid_out || ready_in.
  - Gives full throughput (one beat per cycle) under continuous ready_in.
- Grant selection (combinational, from valid_in, pointer, lock state):
  - locked=1: candidate = lock_idx only. If valid_in[lock_idx]=0, no grant that cycle; other channels are not served.
  - locked=0, MODE=0: first k with valid_in[k]=1, scanning pointer, pointer+1, … BUS_NUM-1, 0, … pointer-1.
  - locked=0, MODE=1: lowest k with valid_in[k]=1.
- ready_out[g] = load & grant_valid & (k==g); all other bits 0.
  - ready_out may depend combinationally on ready_in. valid_in must not depend on ready_out.
- Transfer on channel g: valid_in[g] & ready_out[g].
  - Next cycle: valid_out=1, data_out=data_in[g], last_out=last_in[g], src_out=g. Latency is 1 cycle.
- If load=1 and there is no transfer: valid_out goes 0 next cycle; data_out, last_out and src_out keep their old values.
- Stall (valid_out=1 & ready_in=0): all outputs hold stable; ready_out is all-zero.
- Lock (PKT_LOCK=1):
  - A transfer with last_in[g]=0 sets locked=1, lock_idx=g.
  - A transfer with last_in[g]=1 clears locked.
  - A single-beat packet (last=1 on first beat) never locks.
- Lock (PKT_LOCK=0): locked stays 0; every beat is treated as packet-final for pointer update.
- RR pointer update (MODE=0): on a packet-final transfer from g, pointer = (g==BUS_NUM-1) ? 0 : g+1.
  - Wrap is explicit for non-power-of-2 BUS_NUM.
  - The pointer is unchanged during mid-packet beats and idle cycles.
  - In MODE=1 the pointer is unused and held at 0.
- Simultaneous events:
  - A new grant is loaded in the same cycle the downstream consumes the old beat (load via ready_in).
  - Lock set/clear and pointer update occur in that same edge.
- Integrity: no beat is dropped or duplicated; beats of one packet are never interleaved with another channel's beats when PKT_LOCK=1.
- Reset mid-packet: lock is discarded. Afterwards arbitration restarts from pointer 0; the upstream remainder is treated as a new packet.

Test Plan:
- Reset behaviour: BUS_NUM=5, DW=8, MODE=0, all valid_in=1, ready_in=1, rst held 3 cycles -> ready_out=0 and valid_out=0 during reset.
  - After release: grants in order 0,1,2,3,4,0 on consecutive cycles.
  - data_out follows one cycle later; src_out matches each grant.
- Round-robin wrap: only channels 4 and 0 valid, last_in=all 1 -> grants alternate 4,0,4,0; pointer wraps 4→0 with no gap cycle.
- Packet lock: PKT_LOCK=1, channel 2 sends 3 beats (last on beat 3) while channel 1 is valid throughout, and channel 2 drops valid for 1 cycle mid-packet.
  - Output order: 2,2,(bubble),2, then 1.
  - No channel-1 beat appears before channel 2's last beat.
- Backpressure: ready_in=0 for 4 cycles with valid_out=1, data 0xA5 -> data_out, last_out, src_out stable at 0xA5; ready_out=0.
  - When ready_in returns to 1, exactly one new beat is accepted per cycle; scoreboard shows no loss or duplication.
- Fixed priority: MODE=1, valid_in=5'b10110 -> channel 1 is granted every cycle while valid; channel 4 is served only after channels 1 and 2 deassert.
- Reset mid-packet: assert rst after beat 2 of a locked 4-beat packet from channel 3 while channel 0 is valid -> after release, channel 0 is granted first (pointer=0, locked=0).
